// File: rtl/fpga_robots_game_keycode_arbiter.sv
`default_nettype none
// ============================================================================
// fpga_robots_game_keycode_arbiter : merges PS/2 and serial keycode bytes into
// one spaced, prefix-atomic stream.                              Rev 1.0
// ============================================================================
module fpga_robots_game_keycode_arbiter_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_i,
  input  logic [7:0] wdat_i,
  input  logic       rd_i,
  output logic [7:0] rdat_o,
  output logic       empty_o,
  output logic       ovf_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic [AW:0]   cnt_q;
  logic          full;
  logic          wr_ok;

  // A full FIFO still takes a write when its head leaves at the same edge.
  assign full    = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign wr_ok   = wr_i && (!full || rd_i);
  assign ovf_o   = wr_i && full && !rd_i;
  assign rdat_o  = mem_q[rp_q];

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wp_q] <= wdat_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_ok) wp_q <= wp_q + 1'b1;
      if (rd_i)  rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_i};
    end
  end
endmodule

module fpga_robots_game_keycode_arbiter #(
  parameter int DEPTH        = 4,
  parameter int GAP          = 1,
  parameter int LOCK_TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ps2_rx_dat,
  input  logic       ps2_rx_stb,
  input  logic [7:0] ser_kc_dat,
  input  logic       ser_kc_stb,
  input  logic       ovf_clr,
  output logic [7:0] kc_dat,
  output logic       kc_stb,
  output logic       kc_src,
  output logic [1:0] ovf,
  output logic       lock_abort
);
  localparam logic [2:0]  GAP_INIT = 3'(GAP);
  localparam logic [15:0] TO_LAST  = 16'(LOCK_TIMEOUT - 1);

  logic [7:0]  head_ps2, head_ser, gdat;
  logic [1:0]  empty, ovf_set, elig;
  logic        grant, gsrc, pop_ps2, pop_ser, lock_empty;

  logic [7:0]  kc_dat_q, kc_dat_d;
  logic        kc_stb_q, kc_stb_d;
  logic        kc_src_q, kc_src_d;
  logic [1:0]  ovf_q, ovf_d;
  logic        abort_q, abort_d;
  logic        lock_q, lock_d;
  logic        lock_src_q, lock_src_d;
  logic        last_q, last_d;
  logic [2:0]  gap_q, gap_d;
  logic [15:0] to_q, to_d;

  fpga_robots_game_keycode_arbiter_fifo #(.DEPTH(DEPTH)) u_ps2_fifo (
    .clk(clk), .rst_n(rst_n), .wr_i(ps2_rx_stb), .wdat_i(ps2_rx_dat), .rd_i(pop_ps2),
    .rdat_o(head_ps2), .empty_o(empty[0]), .ovf_o(ovf_set[0])
  );

  fpga_robots_game_keycode_arbiter_fifo #(.DEPTH(DEPTH)) u_ser_fifo (
    .clk(clk), .rst_n(rst_n), .wr_i(ser_kc_stb), .wdat_i(ser_kc_dat), .rd_i(pop_ser),
    .rdat_o(head_ser), .empty_o(empty[1]), .ovf_o(ovf_set[1])
  );

  // While locked only the lock holder can be eligible, so a tie implies unlocked.
  always_comb begin
    elig[0]    = !empty[0] && (gap_q == 3'd0) && (!lock_q || !lock_src_q);
    elig[1]    = !empty[1] && (gap_q == 3'd0) && (!lock_q ||  lock_src_q);
    grant      = |elig;
    gsrc       = (&elig) ? ~last_q : elig[1];
    gdat       = gsrc ? head_ser : head_ps2;
    pop_ps2    = grant && !gsrc;
    pop_ser    = grant &&  gsrc;
    lock_empty = lock_src_q ? empty[1] : empty[0];
  end

  always_comb begin
    kc_dat_d   = kc_dat_q;
    kc_src_d   = kc_src_q;
    kc_stb_d   = grant;
    abort_d    = 1'b0;
    last_d     = last_q;
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    gap_d      = (gap_q != 3'd0) ? gap_q - 3'd1 : 3'd0;
    to_d       = to_q;
    ovf_d      = (ovf_q & ~{2{ovf_clr}}) | ovf_set;
    if (grant) begin
      kc_dat_d = gdat;
      kc_src_d = gsrc;
      last_d   = gsrc;
      gap_d    = GAP_INIT;
      to_d     = '0;
      if (gdat == 8'hE0 || gdat == 8'hF0) begin
        lock_d     = 1'b1;
        lock_src_d = gsrc;
      end else if (lock_q && (lock_src_q == gsrc)) begin
        lock_d = 1'b0;
      end
    end else if (lock_q && lock_empty) begin
      if (to_q >= TO_LAST) begin
        lock_d  = 1'b0;
        abort_d = 1'b1;
        to_d    = '0;
      end else begin
        to_d = to_q + 16'd1;
      end
    end else if (!lock_q) begin
      to_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kc_dat_q   <= '0;
      kc_stb_q   <= 1'b0;
      kc_src_q   <= 1'b0;
      ovf_q      <= '0;
      abort_q    <= 1'b0;
      lock_q     <= 1'b0;
      lock_src_q <= 1'b0;
      last_q     <= 1'b1;
      gap_q      <= '0;
      to_q       <= '0;
    end else begin
      kc_dat_q   <= kc_dat_d;
      kc_stb_q   <= kc_stb_d;
      kc_src_q   <= kc_src_d;
      ovf_q      <= ovf_d;
      abort_q    <= abort_d;
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      last_q     <= last_d;
      gap_q      <= gap_d;
      to_q       <= to_d;
    end
  end

  assign kc_dat     = kc_dat_q;
  assign kc_stb     = kc_stb_q;
  assign kc_src     = kc_src_q;
  assign ovf        = ovf_q;
  assign lock_abort = abort_q;
endmodule
`default_nettype wire

// File: tb/tb_fpga_robots_game_keycode_arbiter.sv
`default_nettype none
// ============================================================================
// tb_fpga_robots_game_keycode_arbiter : scoreboard bench for the keycode arbiter.
// Rev 1.0
// ============================================================================
module tb_fpga_robots_game_keycode_arbiter;
  localparam int DEPTH        = 4;
  localparam int GAP          = 1;
  localparam int LOCK_TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ps2_rx_dat = '0;
  logic       ps2_rx_stb = 1'b0;
  logic [7:0] ser_kc_dat = '0;
  logic       ser_kc_stb = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] kc_dat;
  logic       kc_stb;
  logic       kc_src;
  logic [1:0] ovf;
  logic       lock_abort;

  fpga_robots_game_keycode_arbiter #(
    .DEPTH(DEPTH), .GAP(GAP), .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ps2_rx_dat(ps2_rx_dat), .ps2_rx_stb(ps2_rx_stb),
    .ser_kc_dat(ser_kc_dat), .ser_kc_stb(ser_kc_stb),
    .ovf_clr(ovf_clr),
    .kc_dat(kc_dat), .kc_stb(kc_stb), .kc_src(kc_src),
    .ovf(ovf), .lock_abort(lock_abort)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];     // {src, dat} in required issue order
  int stb_cyc_q[$];
  int prev_stb = -100;
  int abort_cnt = 0;
  int abort_cyc = 0;
  int c0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    if (kc_stb) begin
      stb_cyc_q.push_back(cyc);
      check("stb_spacing", int'((cyc - prev_stb) >= GAP + 1), 1);
      prev_stb = cyc;
      check("stb_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("kc_dat", int'(kc_dat), int'(e[7:0]));
        check("kc_src", int'(kc_src), int'(e[8]));
      end
    end
    if (lock_abort) begin
      abort_cnt++;
      abort_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic pv, input logic [7:0] pd, input logic sv, input logic [7:0] sd);
    ps2_rx_stb = pv; ps2_rx_dat = pd;
    ser_kc_stb = sv; ser_kc_dat = sd;
    tick();
    ps2_rx_stb = 1'b0;
    ser_kc_stb = 1'b0;
  endtask

  task automatic check_lat(input string tag, input int idx, input int base, input int lat);
    if (stb_cyc_q.size() > idx) check(tag, stb_cyc_q[idx] - base, lat);
    else check({tag, "_missing"}, stb_cyc_q.size(), idx + 1);
  endtask

  task automatic new_test();
    stb_cyc_q.delete();
    abort_cnt = 0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
    exp_q.delete();
    prev_stb = -100;
    new_test();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_kc_dat"}, int'(kc_dat), 0);
    check({tag, "_kc_stb"}, int'(kc_stb), 0);
    check({tag, "_kc_src"}, int'(kc_src), 0);
    check({tag, "_ovf"}, int'(ovf), 0);
    check({tag, "_lock_abort"}, int'(lock_abort), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(3);
    check_idle_outputs("reset");

    // Single PS/2 byte: two-cycle latency
    new_test();
    c0 = cyc;
    exp_q.push_back({1'b0, 8'h1D});
    send(1'b1, 8'h1D, 1'b0, 8'h00);
    repeat (6) tick();
    check("single_count", stb_cyc_q.size(), 1);
    check_lat("single_lat", 0, c0, 2);
    check("single_ovf", int'(ovf), 0);

    // Tie after a PS/2 grant: round-robin picks serial first
    new_test();
    c0 = cyc;
    exp_q.push_back({1'b1, 8'h1B});
    exp_q.push_back({1'b0, 8'h1D});
    send(1'b1, 8'h1D, 1'b1, 8'h1B);
    repeat (8) tick();
    check("rr_count", stb_cyc_q.size(), 2);
    check_lat("rr_lat0", 0, c0, 2);
    check_lat("rr_lat1", 1, c0, 4);

    // Tie straight out of reset: PS/2 first
    do_reset(1);
    c0 = cyc;
    exp_q.push_back({1'b0, 8'h1D});
    exp_q.push_back({1'b1, 8'h1B});
    send(1'b1, 8'h1D, 1'b1, 8'h1B);
    repeat (8) tick();
    check("tie_count", stb_cyc_q.size(), 2);
    check_lat("tie_lat0", 0, c0, 2);
    check_lat("tie_lat1", 1, c0, 4);

    // E0 prefix holds the lock; serial 0x29 waits until 0x75 completes the pair
    new_test();
    c0 = cyc;
    exp_q.push_back({1'b0, 8'hE0});
    send(1'b1, 8'hE0, 1'b0, 8'h00);
    send(1'b0, 8'h00, 1'b1, 8'h29);
    repeat (2) tick();
    exp_q.push_back({1'b0, 8'h75});
    exp_q.push_back({1'b1, 8'h29});
    send(1'b1, 8'h75, 1'b0, 8'h00);
    repeat (10) tick();
    check("prefix_count", stb_cyc_q.size(), 3);
    check_lat("prefix_lat_e0", 0, c0, 2);
    check_lat("prefix_lat_75", 1, c0, 6);
    check_lat("prefix_lat_29", 2, c0, 8);
    check("prefix_no_abort", abort_cnt, 0);

    // Nine back-to-back PS/2 bytes: eighth lands on a full FIFO being read, ninth drops
    new_test();
    c0 = cyc;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) check("ovf_full_read_accepts", int'(ovf), 0);
      if (i < 8) exp_q.push_back({1'b0, 8'(8'h10 + i)});
      send(1'b1, 8'(8'h10 + i), 1'b0, 8'h00);
    end
    check("ovf_set", int'(ovf), 1);
    repeat (20) tick();
    check("ovf_count", stb_cyc_q.size(), 8);
    check("ovf_sticky", int'(ovf), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", int'(ovf), 0);

    // Lone F0 times out, then the queued serial byte issues
    new_test();
    c0 = cyc;
    exp_q.push_back({1'b0, 8'hF0});
    send(1'b1, 8'hF0, 1'b0, 8'h00);
    exp_q.push_back({1'b1, 8'h1B});
    send(1'b0, 8'h00, 1'b1, 8'h1B);
    repeat (14) tick();
    check("abort_count", abort_cnt, 1);
    check("abort_cycle", abort_cyc - c0, 10);
    check("abort_stb_count", stb_cyc_q.size(), 2);
    check_lat("abort_lat_1b", 1, c0, 11);

    // Reset while E0 is locked and both FIFOs hold data
    new_test();
    c0 = cyc;
    exp_q.push_back({1'b0, 8'hE0});
    send(1'b1, 8'hE0, 1'b0, 8'h00);
    tick();
    send(1'b1, 8'h11, 1'b1, 8'h22);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_idle_outputs("midreset");
    check("midreset_e0_issued", exp_q.size(), 0);
    check("midreset_stb_count", stb_cyc_q.size(), 1);
    new_test();
    prev_stb = -100;
    c0 = cyc;
    exp_q.push_back({1'b1, 8'h1B});
    send(1'b0, 8'h00, 1'b1, 8'h1B);
    exp_q.push_back({1'b0, 8'h1D});
    send(1'b1, 8'h1D, 1'b0, 8'h00);
    repeat (12) tick();
    check("post_reset_count", stb_cyc_q.size(), 2);
    check_lat("post_reset_lat_1b", 0, c0, 2);
    check_lat("post_reset_lat_1d", 1, c0, 4);
    check("post_reset_no_abort", abort_cnt, 0);

    check("final_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
